aes128_decrypt_iter: RTL
========================

// Module: aes128_decrypt_iter
// PURPOSE
//  Iterative AES-128 decryptor. Inverse of the encrypt datapath: one inverse round per clock.
//  Takes a ciphertext and the round-10 key (the last encryption round key).
//  Derives round keys 9..0 on the fly with the inverse key schedule; no key RAM.
//  Sits beside the encrypt core; valid/ready handshake on both ends.
// PARAMETERS
//  (none) -- AES-128 only, Nr = 10 fixed
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    ct_in/key_last valid
//  in_ready   out  1    core idle, accepts a block
//  ct_in      in   128  ciphertext; [127:120] = byte 0 (FIPS-197 order)
//  key_last   in   128  round-10 key, same byte order
//  out_valid  out  1    pt_out valid
//  out_ready  in   1    consumer accepts pt_out
//  pt_out     out  128  plaintext
// BEHAVIOUR
//  Reset (async, active-high): FSM=IDLE, in_ready=1, out_valid=0, pt_out=0, state/rk/rnd regs=0.
//  FSM: IDLE -> ROUND on in_valid&in_ready; ROUND -> DONE when rnd==1; DONE -> IDLE on out_ready.
//  in_ready=1 only in IDLE. out_valid=1 only in DONE.
//  Accept edge: st<=ct_in^key_last; rk<=key_last; rnd<=10.
//  Each ROUND cycle, with rk holding the key for round rnd:
//   rk_prev = inv_key_step(rk, rcon[rnd]).
//   Words a0..a3 = rk[127:96..31:0]:
//    b3=a3^a2; b2=a2^a1; b1=a1^a0; b0=a0^SubWord(RotWord(b3))^rcon.
//   rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (in the MSB of the word).
//   rnd>1:  st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^rk_prev); rk<=rk_prev; rnd<=rnd-1.
//   rnd==1: pt_out<=InvSubBytes(InvShiftRows(st))^rk_prev; go to DONE.
//  Latency: out_valid rises exactly 10 cycles after the accept edge.
//   Throughput: one block per 11+ cycles.
//  pt_out is held stable while out_valid=1 and out_ready=0 (backpressure; no limit).
//  The DONE->IDLE edge clears out_valid. pt_out keeps its value (don't care once out_valid=0).
//  in_valid during ROUND/DONE: ignored. Inputs are sampled only on the accept edge.
//   Changing ct_in/key_last mid-block has no effect.
//  rst mid-block: block aborted, all regs return to reset values immediately. No partial output.
//  rnd is 4 bits; values 0 and 11..15 are unreachable. If reached, the FSM forces IDLE.
// STRUCTURE
//  Shared package aes_pkg:
//   - RCON table as a function indexed 1..10
//   - FSM state encoding (IDLE=2'd0, ROUND=2'd1, DONE=2'd2)
//   - GF(2^8) xtime/mul helpers: 9, b, d, e
//  Sub-module aes_inv_key_step (combinational):
//   - in rk[127:0], rcon[7:0]; out rk_prev[127:0]
//   - contains the 4 forward S-box lookups for SubWord
//  Inverse S-box, InvShiftRows and InvMixColumns: combinational helper modules
//   (inv_substitute_bytes, inv_shift_rows, inv_mix_columns), same 128-bit in/out style as
//   the forward ones.
// TESTING
//  T1 FIPS-197 App.B:
//   ct=3925841d02dc09fbdc118597196a0b32, key_last=d014f9a8c9ee2589e13f0cc8b6630ca6
//   -> pt_out=3243f6a8885a308d313198a2e0370734, out_valid 10 cycles after accept.
//  T2 FIPS-197 C.1:
//   ct=69c4e0d86a7b0430d8cdb78070b4c55a, key_last=13111d7fe3944a17f307a78b4d2b30c5
//   -> pt_out=00112233445566778899aabbccddeeff.
//  T3 backpressure: out_ready=0 for 20 cycles after T1 completes
//   -> pt_out/out_valid stable, in_ready=0; out_ready=1 -> next cycle IDLE, in_ready=1.
//  T4 back-to-back: T1 then T2 with in_valid held high
//   -> second accept on the first IDLE cycle, both results correct, in order.
//  T5 reset mid-block: assert rst at round 5 of T1
//   -> out_valid=0, in_ready=1 asynchronously; T2 afterwards gives the correct pt.
//  T6 input churn: randomize ct_in/key_last during ROUND of T2 -> result still the T2 plaintext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, round constants and GF(2^8) arithmetic
// used by the iterative decryptor and its key-schedule step.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } dec_state_e;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (x & {8{b[i]}});
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One step of the AES-128 key schedule run backwards: round key r -> round key r-1.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_prev
);

    logic [31:0] a0_s, a1_s, a2_s, a3_s;
    logic [31:0] b0_s, b1_s, b2_s, b3_s;
    logic [31:0] rot_s, sub_s;

    assign a0_s = rk[127:96];
    assign a1_s = rk[95:64];
    assign a2_s = rk[63:32];
    assign a3_s = rk[31:0];

    assign b3_s = a3_s ^ a2_s;
    assign b2_s = a2_s ^ a1_s;
    assign b1_s = a1_s ^ a0_s;

    // the first word needs the last word of the previous key, which is b3
    assign rot_s = {b3_s[23:0], b3_s[31:24]};
    assign sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    assign b0_s  = a0_s ^ sub_s ^ {rcon, 24'h000000};

    assign rk_prev = {b0_s, b1_s, b2_s, b3_s};

endmodule

// File: rtl/inv_mix_columns.sv
// InvMixColumns: each column multiplied by the {0e,0b,0d,09} circulant matrix.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0_s, a1_s, a2_s, a3_s;
        assign a0_s = din[127-32*c -: 8];
        assign a1_s = din[119-32*c -: 8];
        assign a2_s = din[111-32*c -: 8];
        assign a3_s = din[103-32*c -: 8];
        assign dout[127-32*c -: 8] = mul_e(a0_s) ^ mul_b(a1_s) ^ mul_d(a2_s) ^ mul_9(a3_s);
        assign dout[119-32*c -: 8] = mul_9(a0_s) ^ mul_e(a1_s) ^ mul_b(a2_s) ^ mul_d(a3_s);
        assign dout[111-32*c -: 8] = mul_d(a0_s) ^ mul_9(a1_s) ^ mul_e(a2_s) ^ mul_b(a3_s);
        assign dout[103-32*c -: 8] = mul_b(a0_s) ^ mul_d(a1_s) ^ mul_9(a2_s) ^ mul_e(a3_s);
    end

endmodule

// File: rtl/inv_shift_rows.sv
// InvShiftRows on a 128-bit state, byte 0 in [127:120], column-major.
module inv_shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    // row r rotates right by r columns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c-r+4)%4)+r) -: 8];
        end
    end

endmodule

// File: rtl/inv_substitute_bytes.sv
// InvSubBytes: inverse S-box applied to all 16 state bytes.
module inv_substitute_bytes
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = inv_sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys derived
// backwards from the round-10 key, valid/ready on both sides.
module aes128_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    input  logic [127:0] key_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out
);
    import aes_pkg::*;

    dec_state_e   state_r, state_nxt_s;
    logic [127:0] st_r, rk_r, pt_r;
    logic [3:0]   rnd_r;
    logic         in_ready_s, out_valid_s, step_s, last_s, accept_s;
    logic [127:0] isr_s, isb_s, ark_s, imc_s, rk_prev_s;
    logic [7:0]   rcon_s;

    assign rcon_s = rcon_of(rnd_r);

    inv_shift_rows       u_isr (.din(st_r),  .dout(isr_s));
    inv_substitute_bytes u_isb (.din(isr_s), .dout(isb_s));
    inv_mix_columns      u_imc (.din(ark_s), .dout(imc_s));
    aes_inv_key_step     u_iks (.rk(rk_r), .rcon(rcon_s), .rk_prev(rk_prev_s));

    assign ark_s = isb_s ^ rk_prev_s;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic; out-of-range round counts fall back to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nxt_s = ST_ROUND;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ROUND: begin
                if (rnd_r == 4'd1)                           state_nxt_s = ST_DONE;
                else if (rnd_r == 4'd0 || rnd_r > 4'd10)     state_nxt_s = ST_IDLE;
                else                                         state_nxt_s = ST_ROUND;
            end
            ST_DONE: begin
                if (out_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // state decode into handshake flags and datapath enables
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_ROUND: begin
                if (rnd_r == 4'd1)                           last_s = 1'b1;
                else if (rnd_r >= 4'd2 && rnd_r <= 4'd10)    step_s = 1'b1;
                else begin
                    last_s = 1'b0;
                    step_s = 1'b0;
                end
            end
            ST_DONE: out_valid_s = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s  = in_valid & in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign pt_out    = pt_r;

    // round datapath: load on accept, one inverse round per ROUND cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r  <= 128'h0;
            rk_r  <= 128'h0;
            pt_r  <= 128'h0;
            rnd_r <= 4'd0;
        end else if (accept_s) begin
            st_r  <= ct_in ^ key_last;
            rk_r  <= key_last;
            rnd_r <= 4'd10;
        end else if (step_s) begin
            st_r  <= imc_s;
            rk_r  <= rk_prev_s;
            rnd_r <= rnd_r - 4'd1;
        end else if (last_s) begin
            pt_r  <= ark_s;
        end
    end

endmodule
